// File: rtl/pll_startup_sequencer_if.sv
// Signal bundle between the PLL startup sequencer, the housekeeping config registers and the PLL.
// The master side is the system (config registers, PLL model); the sequencer is the slave.
interface pll_startup_sequencer_if;
  logic        run;
  logic        cfg_req;
  logic [4:0]  cfg_div;
  logic        cfg_dco;
  logic [25:0] cfg_trim;
  logic        cfg_ack;
  logic [7:0]  exp_count;
  logic        pll_div_clk;
  logic        pll_enable;
  logic        pll_resetb;
  logic [4:0]  pll_div;
  logic        pll_dco;
  logic [25:0] pll_trim;
  logic        clk_sel;
  logic        locked;
  logic        fail;
  logic        busy;
  logic [7:0]  meas_count;

  modport master (
    output run, cfg_req, cfg_div, cfg_dco, cfg_trim, exp_count, pll_div_clk,
    input  cfg_ack, pll_enable, pll_resetb, pll_div, pll_dco, pll_trim,
    input  clk_sel, locked, fail, busy, meas_count
  );

  modport slave (
    input  run, cfg_req, cfg_div, cfg_dco, cfg_trim, exp_count, pll_div_clk,
    output cfg_ack, pll_enable, pll_resetb, pll_div, pll_dco, pll_trim,
    output clk_sel, locked, fail, busy, meas_count
  );
endinterface

// File: rtl/pll_startup_sequencer.sv
// PLL/DCO bring-up sequencer: reset, settle, frequency-qualify, then hand the core clock over.
// The core is always moved back to the reference clock before the PLL is reconfigured.
module pll_startup_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned WINDOW        = 256,
  parameter int unsigned SW_CYCLES     = 4,
  parameter int unsigned TOL           = 2,
  parameter int unsigned MAX_RETRY     = 3
) (
  input logic                    clock,
  input logic                    reset,
  pll_startup_sequencer_if.slave bus
);

  // An edge on pll_div_clk reaches the counter this many cycles later, so the
  // counting window is delayed by the same amount to line up with the raw input.
  localparam int unsigned SyncLat    = 3;
  localparam int unsigned MeasCycles = SyncLat + WINDOW;
  localparam int unsigned MaxAb      = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MaxCd      = (MeasCycles > SW_CYCLES) ? MeasCycles : SW_CYCLES;
  localparam int unsigned MaxCnt     = (MaxAb > MaxCd) ? MaxAb : MaxCd;
  localparam int unsigned CntW       = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam int unsigned RetryW     = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [2:0] StOff      = 3'd0;
  localparam logic [2:0] StReset    = 3'd1;
  localparam logic [2:0] StSettle   = 3'd2;
  localparam logic [2:0] StMeasure  = 3'd3;
  localparam logic [2:0] StSwitch   = 3'd4;
  localparam logic [2:0] StLocked   = 3'd5;
  localparam logic [2:0] StUnswitch = 3'd6;
  localparam logic [2:0] StFail     = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [7:0]        edge_cnt_q, edge_cnt_d;
  logic [7:0]        meas_q, meas_d;
  logic              cfg_ack_q, cfg_ack_d;
  logic [4:0]        div_q;
  logic              dco_q;
  logic [25:0]       trim_q;
  logic              sync1_q, sync2_q, sync3_q;
  logic              enable_q, enable_d;
  logic              resetb_q, resetb_d;
  logic              clk_sel_q, clk_sel_d;
  logic              locked_q, locked_d;
  logic              fail_q, fail_d;
  logic              busy_q, busy_d;

  logic              edge_pulse;
  logic              req_valid;
  logic [7:0]        edge_sum;
  logic signed [8:0] diff;
  logic [8:0]        err;
  logic              meas_pass;

  assign edge_pulse = sync2_q & ~sync3_q;
  // A request still high in the ack cycle is the same request, not a new one.
  assign req_valid  = bus.cfg_req & ~cfg_ack_q;
  assign edge_sum   = (edge_pulse && (edge_cnt_q != 8'hff)) ? edge_cnt_q + 8'd1 : edge_cnt_q;
  assign diff       = $signed({1'b0, edge_sum}) - $signed({1'b0, bus.exp_count});
  assign err        = diff[8] ? (~diff + 9'd1) : diff;
  assign meas_pass  = (err <= 9'(TOL));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    edge_cnt_d = edge_cnt_q;
    meas_d     = meas_q;
    cfg_ack_d  = 1'b0;
    case (state_q)
      StOff: begin
        cnt_d = '0;
        if (req_valid) begin
          cfg_ack_d = 1'b1;
        end else if (bus.run) begin
          state_d = StReset;
          retry_d = '0;
        end
      end
      StReset: begin
        if (!bus.run) begin
          state_d = StOff;
        end else if (cnt_q == CntW'(RST_CYCLES - 1)) begin
          state_d = StSettle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSettle: begin
        if (!bus.run) begin
          state_d = StOff;
        end else if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
          state_d    = StMeasure;
          cnt_d      = '0;
          edge_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StMeasure: begin
        if (!bus.run) begin
          state_d = StOff;
        end else begin
          if (cnt_q >= CntW'(SyncLat)) begin
            edge_cnt_d = edge_sum;
          end
          if (cnt_q == CntW'(MeasCycles - 1)) begin
            meas_d = edge_sum;
            cnt_d  = '0;
            if (meas_pass) begin
              state_d = StSwitch;
            end else begin
              retry_d = retry_q + RetryW'(1);
              state_d = (retry_q == RetryW'(MAX_RETRY - 1)) ? StFail : StSettle;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StSwitch: begin
        if (!bus.run) begin
          state_d = StOff;
        end else if (cnt_q == CntW'(SW_CYCLES - 1)) begin
          state_d = StLocked;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLocked: begin
        // Hold at least SW_CYCLES after clk_sel rose before it may fall again.
        if (cnt_q != CntW'(SW_CYCLES - 1)) begin
          cnt_d = cnt_q + CntW'(1);
        end else if (req_valid || !bus.run) begin
          state_d = StUnswitch;
          cnt_d   = '0;
        end
      end
      StUnswitch: begin
        if (cnt_q == CntW'(SW_CYCLES - 1)) begin
          cnt_d = '0;
          if (req_valid) begin
            cfg_ack_d = 1'b1;
            retry_d   = '0;
            state_d   = bus.run ? StReset : StOff;
          end else begin
            state_d = StOff;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFail: begin
        if (req_valid) begin
          cfg_ack_d = 1'b1;
          state_d   = StOff;
        end else if (!bus.run) begin
          state_d = StOff;
        end
      end
      default: state_d = StOff;
    endcase
  end

  // Pin levels are a pure function of the next state and are registered with it.
  always_comb begin
    enable_d  = 1'b0;
    resetb_d  = 1'b0;
    clk_sel_d = 1'b0;
    locked_d  = 1'b0;
    fail_d    = 1'b0;
    busy_d    = 1'b0;
    case (state_d)
      StReset: begin
        enable_d = 1'b1;
        busy_d   = 1'b1;
      end
      StSettle, StMeasure, StSwitch, StUnswitch: begin
        enable_d = 1'b1;
        resetb_d = 1'b1;
        busy_d   = 1'b1;
      end
      StLocked: begin
        enable_d  = 1'b1;
        resetb_d  = 1'b1;
        clk_sel_d = 1'b1;
        locked_d  = 1'b1;
      end
      StFail:  fail_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StOff;
      cnt_q      <= '0;
      retry_q    <= '0;
      edge_cnt_q <= '0;
      meas_q     <= '0;
      cfg_ack_q  <= 1'b0;
      div_q      <= '0;
      dco_q      <= 1'b0;
      trim_q     <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      enable_q   <= 1'b0;
      resetb_q   <= 1'b0;
      clk_sel_q  <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      edge_cnt_q <= edge_cnt_d;
      meas_q     <= meas_d;
      cfg_ack_q  <= cfg_ack_d;
      if (cfg_ack_d) begin
        div_q  <= bus.cfg_div;
        dco_q  <= bus.cfg_dco;
        trim_q <= bus.cfg_trim;
      end
      sync1_q    <= bus.pll_div_clk;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      enable_q   <= enable_d;
      resetb_q   <= resetb_d;
      clk_sel_q  <= clk_sel_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.cfg_ack    = cfg_ack_q;
  assign bus.pll_enable = enable_q;
  assign bus.pll_resetb = resetb_q;
  assign bus.pll_div    = div_q;
  assign bus.pll_dco    = dco_q;
  assign bus.pll_trim   = trim_q;
  assign bus.clk_sel    = clk_sel_q;
  assign bus.locked     = locked_q;
  assign bus.fail       = fail_q;
  assign bus.busy       = busy_q;
  assign bus.meas_count = meas_q;

  ack_one_cycle: assert property (@(posedge clock) disable iff (reset) cfg_ack_q |=> !cfg_ack_q);
  locked_on_pll: assert property (@(posedge clock) disable iff (reset) locked_q |-> clk_sel_q);

endmodule

// File: tb/tb_pll_startup_sequencer.sv
// Bench for pll_startup_sequencer: a clock-synchronous PLL model with an exact edge rate per 256
// cycles, and a reference model predicting lock/fail outcome, latency and measured count.
`timescale 1ns/1ps
module tb_pll_startup_sequencer;

  localparam int RST    = 16;
  localparam int SETTLE = 1024;
  localparam int WIN    = 256;
  localparam int SW     = 4;
  localparam int TOL    = 2;
  localparam int MAXR   = 3;
  localparam int SYNC   = 3;
  // Second instance with a long window so the 8-bit count can actually saturate.
  localparam int RST2    = 4;
  localparam int SETTLE2 = 16;
  localparam int WIN2    = 640;

  logic        clock;
  logic        reset;
  logic        gen_clk;
  logic [8:0]  gen_phase;
  int unsigned gen_n;
  int          total;
  int          bad;

  pll_startup_sequencer_if bus ();
  pll_startup_sequencer_if bus2 ();

  assign bus.pll_div_clk  = gen_clk;
  assign bus2.pll_div_clk = gen_clk;

  pll_startup_sequencer #(
    .RST_CYCLES(RST), .SETTLE_CYCLES(SETTLE), .WINDOW(WIN),
    .SW_CYCLES(SW), .TOL(TOL), .MAX_RETRY(MAXR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  pll_startup_sequencer #(
    .RST_CYCLES(RST2), .SETTLE_CYCLES(SETTLE2), .WINDOW(WIN2),
    .SW_CYCLES(SW), .TOL(TOL), .MAX_RETRY(MAXR)
  ) dut2 (
    .clock(clock),
    .reset(reset),
    .bus  (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Phase accumulator: exactly gen_n rising edges in any 256 consecutive cycles.
  initial begin
    gen_n     = 0;
    gen_phase = 9'($urandom_range(511, 0));
    gen_clk   = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      gen_phase = gen_phase + 9'(2 * gen_n);
      gen_clk   = gen_phase[8];
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [46:0] obs;
    reset = 1'b1;
    bus.run = 1'b0; bus.cfg_req = 1'b0; bus.cfg_div = '0; bus.cfg_dco = 1'b0;
    bus.cfg_trim = '0; bus.exp_count = '0;
    bus2.run = 1'b0; bus2.cfg_req = 1'b0; bus2.cfg_div = '0; bus2.cfg_dco = 1'b0;
    bus2.cfg_trim = '0; bus2.exp_count = '0;
    tick(); tick();
    obs = {bus.pll_enable, bus.pll_resetb, bus.clk_sel, bus.locked, bus.fail, bus.busy,
           bus.cfg_ack, bus.pll_dco, bus.pll_div, bus.pll_trim, bus.meas_count};
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
    obs = {bus2.pll_enable, bus2.pll_resetb, bus2.clk_sel, bus2.locked, bus2.fail, bus2.busy,
           bus2.cfg_ack, bus2.pll_dco, bus2.pll_div, bus2.pll_trim, bus2.meas_count};
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_outputs2: got %h want 0", obs); end
    reset = 1'b0;
    tick(); tick();
    total++;
    if (bus.busy !== 1'b0 || bus.pll_enable !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: got busy=%b en=%b want 0 0", bus.busy, bus.pll_enable);
    end
  endtask

  task automatic do_cfg(input logic [4:0] div, input logic dco, input logic [25:0] trim,
                        input bit hold_extra);
    bus.cfg_req = 1'b1; bus.cfg_div = div; bus.cfg_dco = dco; bus.cfg_trim = trim;
    tick();
    total++;
    if (bus.cfg_ack !== 1'b1 || {bus.pll_div, bus.pll_dco, bus.pll_trim} !== {div, dco, trim}) begin
      bad++;
      $display("FAIL cfg_load: got ack=%b div=%0d dco=%b trim=%h want 1 %0d %b %h",
               bus.cfg_ack, bus.pll_div, bus.pll_dco, bus.pll_trim, div, dco, trim);
    end
    if (hold_extra) begin
      tick();
      total++;
      if (bus.cfg_ack !== 1'b0) begin bad++; $display("FAIL cfg_no_reack: got %b want 0", bus.cfg_ack); end
    end
    bus.cfg_req = 1'b0;
    tick();
    total++;
    if (bus.cfg_ack !== 1'b0 || bus.busy !== 1'b0 || bus.pll_enable !== 1'b0) begin
      bad++;
      $display("FAIL cfg_off_idle: got ack=%b busy=%b en=%b want 0 0 0",
               bus.cfg_ack, bus.busy, bus.pll_enable);
    end
  endtask

  task automatic test_cfg_off();
    do_cfg(5'd8, 1'b0, 26'd0, 1'b1);
  endtask

  // Raise run and follow the bring-up to LOCKED or FAIL, checking against the model.
  task automatic bring_up(input int n, input int expc);
    int cnt_model, want_cyc, cyc;
    bit pass, done;
    cnt_model = (n > 255) ? 255 : n;
    pass      = (cnt_model - expc <= TOL) && (expc - cnt_model <= TOL);
    want_cyc  = pass ? 1 + RST + SETTLE + SYNC + WIN + SW : 1 + RST + MAXR * (SETTLE + SYNC + WIN);
    gen_n         = n;
    bus.exp_count = 8'(expc);
    bus.run       = 1'b1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 6000) begin
      tick();
      cyc++;
      if (cyc == RST) begin
        total++;
        if (bus.pll_resetb !== 1'b0 || bus.pll_enable !== 1'b1) begin
          bad++; $display("FAIL resetb_low: got %b want 0", bus.pll_resetb);
        end
      end
      if (cyc == RST + 1) begin
        total++;
        if (bus.pll_resetb !== 1'b1) begin bad++; $display("FAIL resetb_rise: got %b want 1", bus.pll_resetb); end
      end
      if (bus.locked || bus.fail) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++; $display("FAIL bringup_timeout: got no outcome after %0d want %0d", cyc, want_cyc);
    end else if (cyc != want_cyc) begin
      bad++; $display("FAIL bringup_latency: got %0d want %0d", cyc, want_cyc);
    end
    total++;
    if (bus.locked !== pass || bus.fail !== !pass || bus.clk_sel !== pass || bus.pll_enable !== pass) begin
      bad++;
      $display("FAIL bringup_outcome: got lk=%b fl=%b sel=%b en=%b want pass=%b",
               bus.locked, bus.fail, bus.clk_sel, bus.pll_enable, pass);
    end
    total++;
    if (bus.meas_count !== 8'(cnt_model)) begin
      bad++; $display("FAIL meas_count: got %0d want %0d", bus.meas_count, cnt_model);
    end
  endtask

  task automatic go_idle();
    int cyc;
    bus.run = 1'b0;
    cyc = 0;
    while ((bus.busy || bus.locked || bus.fail) && cyc < 40) begin
      tick();
      cyc++;
    end
    total++;
    if (bus.busy || bus.locked || bus.fail || bus.clk_sel || bus.pll_enable) begin
      bad++;
      $display("FAIL go_idle: got busy=%b lk=%b fl=%b sel=%b en=%b want all 0",
               bus.busy, bus.locked, bus.fail, bus.clk_sel, bus.pll_enable);
    end
  endtask

  task automatic test_lock_nominal();
    bring_up(64, 64);
    go_idle();
  endtask

  task automatic test_retry_fail();
    bring_up(67, 64);
    bus.run = 1'b0;
    tick();
    total++;
    if (bus.fail !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL fail_exit: got fail=%b busy=%b want 0 0", bus.fail, bus.busy);
    end
  endtask

  task automatic test_tol_edge();
    bring_up(66, 64);
  endtask

  task automatic test_reconfig();
    int cyc;
    repeat (5) tick();
    bus.cfg_req = 1'b1; bus.cfg_div = 5'd10; bus.cfg_dco = 1'b0; bus.cfg_trim = 26'h155;
    tick();
    total++;
    if (bus.clk_sel !== 1'b0 || bus.locked !== 1'b0 || bus.cfg_ack !== 1'b0) begin
      bad++;
      $display("FAIL unswitch_entry: got sel=%b lk=%b ack=%b want 0 0 0", bus.clk_sel, bus.locked, bus.cfg_ack);
    end
    for (int i = 0; i < SW - 1; i++) begin
      tick();
      total++;
      if (bus.cfg_ack !== 1'b0 || bus.pll_div !== 5'd8) begin
        bad++; $display("FAIL ack_guard: got ack=%b div=%0d want 0 8", bus.cfg_ack, bus.pll_div);
      end
    end
    tick();
    total++;
    if (bus.cfg_ack !== 1'b1 || bus.pll_div !== 5'd10 || bus.pll_trim !== 26'h155) begin
      bad++; $display("FAIL reconfig_ack: got ack=%b div=%0d want 1 10", bus.cfg_ack, bus.pll_div);
    end
    bus.cfg_req = 1'b0;
    tick();
    total++;
    if (bus.cfg_ack !== 1'b0 || bus.busy !== 1'b1 || bus.pll_resetb !== 1'b0 || bus.pll_enable !== 1'b1) begin
      bad++;
      $display("FAIL rerun_reset: got ack=%b busy=%b rb=%b en=%b want 0 1 0 1",
               bus.cfg_ack, bus.busy, bus.pll_resetb, bus.pll_enable);
    end
    cyc = 1;
    while (!bus.locked && !bus.fail && cyc < 3000) begin
      tick();
      cyc++;
    end
    total++;
    if (bus.locked !== 1'b1 || cyc != RST + SETTLE + SYNC + WIN + SW) begin
      bad++;
      $display("FAIL relock: got lk=%b after %0d want 1 after %0d", bus.locked, cyc,
               RST + SETTLE + SYNC + WIN + SW);
    end
    total++;
    if (bus.meas_count !== 8'd66) begin bad++; $display("FAIL relock_meas: got %0d want 66", bus.meas_count); end
  endtask

  task automatic test_run_drop();
    go_idle();
    gen_n = 64;
    bus.exp_count = 8'd64;
    bus.run = 1'b1;
    repeat (1 + RST + SETTLE + 100) tick();
    total++;
    if (bus.busy !== 1'b1 || bus.pll_resetb !== 1'b1 || bus.clk_sel !== 1'b0) begin
      bad++; $display("FAIL in_measure: got busy=%b rb=%b sel=%b want 1 1 0", bus.busy, bus.pll_resetb, bus.clk_sel);
    end
    bus.run = 1'b0;
    tick();
    total++;
    if (bus.pll_enable !== 1'b0 || bus.busy !== 1'b0 || bus.pll_resetb !== 1'b0) begin
      bad++;
      $display("FAIL run_drop: got en=%b busy=%b rb=%b want 0 0 0", bus.pll_enable, bus.busy, bus.pll_resetb);
    end
  endtask

  task automatic test_sync_reset();
    bring_up(64, 64);
    repeat (2) tick();
    reset   = 1'b1;
    bus.run = 1'b0;
    tick();
    total++;
    if ({bus.clk_sel, bus.locked, bus.pll_enable, bus.pll_div, bus.meas_count} !== '0) begin
      bad++;
      $display("FAIL sync_reset: got sel=%b lk=%b en=%b div=%0d meas=%0d want 0",
               bus.clk_sel, bus.locked, bus.pll_enable, bus.pll_div, bus.meas_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero_edges();
    bring_up(0, 1);
    go_idle();
  endtask

  task automatic test_saturate();
    int cyc, want_cyc, cnt_model;
    cnt_model = (128 * WIN2 / 256 > 255) ? 255 : 128 * WIN2 / 256;
    want_cyc  = 1 + RST2 + SETTLE2 + SYNC + WIN2 + SW;
    gen_n = 128;
    bus2.exp_count = 8'd255;
    repeat (4) tick();
    bus2.run = 1'b1;
    cyc = 0;
    while (!bus2.locked && !bus2.fail && cyc < 2000) begin
      tick();
      cyc++;
    end
    total++;
    if (bus2.locked !== 1'b1 || cyc != want_cyc) begin
      bad++; $display("FAIL sat_lock: got lk=%b after %0d want 1 after %0d", bus2.locked, cyc, want_cyc);
    end
    total++;
    if (bus2.meas_count !== 8'(cnt_model)) begin
      bad++; $display("FAIL sat_count: got %0d want %0d", bus2.meas_count, cnt_model);
    end
    bus2.run = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_random();
    logic [4:0]  div;
    logic        dco;
    logic [25:0] trim;
    int n, expc;
    for (int it = 0; it < 4; it++) begin
      div  = 5'($urandom_range(31, 0));
      dco  = 1'($urandom_range(1, 0));
      trim = 26'($urandom);
      do_cfg(div, dco, trim, 1'b0);
      n    = int'($urandom_range(120, 0));
      expc = n + int'($urandom_range(8, 0)) - 4;
      if (expc < 0) expc = 0;
      bring_up(n, expc);
      total++;
      if ({bus.pll_div, bus.pll_dco, bus.pll_trim} !== {div, dco, trim}) begin
        bad++; $display("FAIL cfg_stable: got div=%0d dco=%b trim=%h want %0d %b %h",
                        bus.pll_div, bus.pll_dco, bus.pll_trim, div, dco, trim);
      end
      go_idle();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    test_reset();
    test_cfg_off();
    test_lock_nominal();
    test_retry_fail();
    test_tol_edge();
    test_reconfig();
    test_run_drop();
    test_sync_reset();
    test_zero_edges();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
